// File: rtl/fft_frame_packer.sv
// Packs multi-channel signed audio into fixed-length frames of complex AXI-Stream words.
// Conversion is select/mix, round half-up, then saturate; frames start and stop only on boundaries.
module fft_frame_packer #(
  parameter int FFT_SIZE   = 2048,
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         enable,
  input  logic                                         mix_en,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
  input  logic [NUM_CH*IN_WIDTH-1:0]                   sample_in,
  input  logic                                         sample_valid,
  output logic                                         sample_ready,
  output logic [2*OUT_WIDTH-1:0]                       tdata,
  output logic                                         tvalid,
  output logic                                         tlast,
  input  logic                                         tready,
  output logic                                         busy,
  output logic                                         overflow
);

  localparam int LOG_CH = $clog2(NUM_CH);
  localparam int SUM_W  = IN_WIDTH + LOG_CH;
  localparam int RND_W  = SUM_W + 1;
  localparam int S      = IN_WIDTH - OUT_WIDTH;
  localparam int CNT_W  = $clog2(FFT_SIZE);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam longint MAX_L = (64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1;
  localparam longint MIN_L = -(64'sd1 <<< (OUT_WIDTH - 1));
  localparam logic signed [RND_W-1:0] MAX_V = RND_W'(MAX_L);
  localparam logic signed [RND_W-1:0] MIN_V = RND_W'(MIN_L);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]     in_cnt, out_cnt;
  logic                 conv_valid;
  logic [OUT_WIDTH-1:0] conv_data, conv_out;
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [OCC_W-1:0]     count, occ;
  logic                 accept, pop, push;

  logic signed [SUM_W-1:0] mix_sum, sel_val;
  logic signed [RND_W-1:0] pre, rounded, shifted;
  int                      shift_amt, ch_idx;

  // Width conversion: the mix shift folds the channel average into the rounding step.
  always_comb begin
    mix_sum = '0;
    sel_val = '0;
    ch_idx  = int'(ch_sel);
    if (ch_idx >= NUM_CH) ch_idx = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      mix_sum = mix_sum + SUM_W'($signed(sample_in[k*IN_WIDTH +: IN_WIDTH]));
      if (k == ch_idx) sel_val = SUM_W'($signed(sample_in[k*IN_WIDTH +: IN_WIDTH]));
    end
    shift_amt = mix_en ? (S + LOG_CH) : S;
    pre       = mix_en ? RND_W'(mix_sum) : RND_W'(sel_val);
    rounded   = pre + (RND_W'(1) << (shift_amt - 1));
    shifted   = rounded >>> shift_amt;
    if (shifted > MAX_V)      conv_out = MAX_V[OUT_WIDTH-1:0];
    else if (shifted < MIN_V) conv_out = MIN_V[OUT_WIDTH-1:0];
    else                      conv_out = shifted[OUT_WIDTH-1:0];
  end

  // The conversion register counts toward occupancy so it can always drain into the FIFO.
  assign occ          = count + OCC_W'(conv_valid);
  assign sample_ready = (state == RUN) && (occ < OCC_W'(FIFO_DEPTH));
  assign accept       = sample_valid && sample_ready;
  assign push         = conv_valid;
  assign tvalid       = (count != '0);
  assign pop          = tvalid && tready;
  assign tdata        = tvalid ? {{OUT_WIDTH{1'b0}}, mem[rd_ptr]} : '0;
  assign tlast        = tvalid && (out_cnt == CNT_W'(FFT_SIZE - 1));
  assign busy         = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (accept && (in_cnt == CNT_W'(FFT_SIZE - 1)) && !enable) state_next = DRAIN;
      DRAIN:   if (!conv_valid && ((count - OCC_W'(pop)) == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      conv_valid <= 1'b0;
      conv_data  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      conv_valid <= accept;
      if (accept) begin
        conv_data <= conv_out;
        in_cnt    <= in_cnt + 1'b1;
      end
      if (sample_valid && (state == RUN) && !sample_ready) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        out_cnt <= out_cnt + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= conv_data;
  end

endmodule
